// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and opcode classification shared by the ALU slice
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  function automatic logic is_single(input logic [3:0] op);
    return op != OP_MULU;
  endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, sum;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // next step: add shifted multiplicand when the current multiplier bit is set
  always_comb begin
    sum     = acc_q + (mplr_q[0] ? mcand_q : '0);
    acc_d   = start ? '0 : (cnt_q != '0 ? sum : acc_q);
    mcand_d = start ? {{WIDTH{1'b0}}, a} : (cnt_q != '0 ? mcand_q << 1 : mcand_q);
    mplr_d  = start ? b : (cnt_q != '0 ? mplr_q >> 1 : mplr_q);
    cnt_d   = start ? CW'(WIDTH) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end

  // the final step's sum is presented directly so the caller can load it on that edge
  assign done    = cnt_q == CW'(1);
  assign product = sum;

  // iteration state; async reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and an iterative unsigned multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, alu_res, b_eff;
  logic               cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic               alu_cout, alu_ovf, sub_op, add_ovf, accept, mul_done;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] product;

  assign in_ready = rst_n && state_q == IDLE && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && !is_single(alu_control)),
    .a       (src1),
    .b       (src2),
    .done    (mul_done),
    .product (product)
  );

  // single-cycle datapath; SLT/SLTU reuse the subtractor's sign, overflow and carry
  always_comb begin
    sub_op   = alu_control inside {OP_SUB, OP_SLT, OP_SLTU};
    b_eff    = sub_op ? ~src2 : src2;
    sum      = {1'b0, src1} + {1'b0, b_eff} + (WIDTH+1)'(sub_op);
    add_ovf  = (src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
    shamt    = src2[SHW-1:0];
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_NAND: alu_res = ~(src1 & src2);
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, !sum[WIDTH]};
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(src1) >>> shamt);
      default: ;
    endcase
  end

  // next-state and output-register loads; results hold while the consumer stalls
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept && is_single(alu_control)) begin
      result_d    = alu_res;
      cout_d      = alu_cout;
      ovf_d       = alu_ovf;
      out_valid_d = 1'b1;
    end else if (accept) begin
      state_d = MUL;
    end else if (state_q == MUL && mul_done) begin
      state_d     = IDLE;
      result_d    = product[WIDTH-1:0];
      cout_d      = |product[2*WIDTH-1:WIDTH];
      ovf_d       = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = result_q == '0;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  logic        iv = 1'b0, ir, ov, ordy = 1'b1, z, co, of;
  logic [31:0] s1 = '0, s2 = '0, res;
  logic [3:0]  op = '0;

  logic        m_iv = 1'b0, m_ir, m_ov, m_ordy = 1'b1, m_z, m_co, m_of;
  logic [7:0]  m_s1 = '0, m_s2 = '0, m_res;
  logic [3:0]  m_op = '0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .src1(s1), .src2(s2),
    .alu_control(op), .out_valid(ov), .out_ready(ordy), .result(res), .zero(z),
    .cout(co), .overflow(of)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .src1(m_s1), .src2(m_s2),
    .alu_control(m_op), .out_valid(m_ov), .out_ready(m_ordy), .result(m_res), .zero(m_z),
    .cout(m_co), .overflow(m_of)
  );

  task automatic op32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; s1 = a; s2 = b; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    m_op = o; m_s1 = a; m_s2 = b; m_iv = 1'b1;
    @(posedge clk); #1;
    m_iv = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL rst_res: got %h want 0", res); end
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", ov); end
    vectors++; if ({z, co, of} !== 3'b100) begin miscompares++; $display("FAIL rst_flags z/co/of: got %b want 100", {z, co, of}); end
    vectors++; if (ir !== 1'b0 || m_ir !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b%b want 00", ir, m_ir); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (ir !== 1'b1 || m_ir !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready: got %b%b want 11", ir, m_ir); end
  endtask

  task automatic test_addsub;
    op32(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    vectors++; if (ov !== 1'b1) begin miscompares++; $display("FAIL add_latency out_valid: got %b want 1", ov); end
    vectors++; if (res !== 32'h8000_0000) begin miscompares++; $display("FAIL add_res: got %h want 80000000", res); end
    vectors++; if ({z, co, of} !== 3'b001) begin miscompares++; $display("FAIL add_flags z/co/of: got %b want 001", {z, co, of}); end
    @(posedge clk); #1;
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL add_drain out_valid: got %b want 0", ov); end
    op32(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    vectors++; if ({res, z, co, of} !== {32'h0, 3'b110}) begin miscompares++; $display("FAIL add_carry: got %h %b want 00000000 110", res, {z, co, of}); end
    op32(OP_SUB, 32'd5, 32'd5);
    vectors++; if ({res, z, co, of} !== {32'h0, 3'b110}) begin miscompares++; $display("FAIL sub_eq: got %h %b want 00000000 110", res, {z, co, of}); end
    op32(OP_SUB, 32'd3, 32'd5);
    vectors++; if ({res, co, of} !== {32'hFFFF_FFFE, 2'b00}) begin miscompares++; $display("FAIL sub_borrow: got %h %b want fffffffe 00", res, {co, of}); end
    op32(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
    vectors++; if ({res, co, of} !== {32'h1, 2'b00}) begin miscompares++; $display("FAIL slt: got %h %b want 00000001 00", res, {co, of}); end
    op32(OP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF);
    vectors++; if ({res, z} !== {32'h0, 1'b1}) begin miscompares++; $display("FAIL sltu: got %h %b want 00000000 1", res, z); end
    op32(OP_SLTU, 32'h7FFF_FFFF, 32'h8000_0000);
    vectors++; if (res !== 32'h1) begin miscompares++; $display("FAIL sltu_lt: got %h want 00000001", res); end
  endtask

  task automatic test_logic;
    op32(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    vectors++; if (res !== 32'hF000_F000) begin miscompares++; $display("FAIL and: got %h want f000f000", res); end
    op32(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    vectors++; if (res !== 32'hFFF0_FFF0) begin miscompares++; $display("FAIL or: got %h want fff0fff0", res); end
    op32(OP_NOR, 32'hF0F0_F0F0, 32'h0F00_0F00);
    vectors++; if (res !== 32'h000F_000F) begin miscompares++; $display("FAIL nor: got %h want 000f000f", res); end
    op32(OP_NAND, 32'hFFFF_0000, 32'hFF00_FF00);
    vectors++; if (res !== 32'h00FF_FFFF) begin miscompares++; $display("FAIL nand: got %h want 00ffffff", res); end
  endtask

  task automatic test_shift;
    op32(OP_SRA, 32'h8000_0000, 32'd4);
    vectors++; if (res !== 32'hF800_0000) begin miscompares++; $display("FAIL sra: got %h want f8000000", res); end
    op32(OP_SRL, 32'h8000_0000, 32'd4);
    vectors++; if (res !== 32'h0800_0000) begin miscompares++; $display("FAIL srl: got %h want 08000000", res); end
    op32(OP_SRL, 32'h8000_0000, 32'h0000_0124);
    vectors++; if (res !== 32'h0800_0000) begin miscompares++; $display("FAIL srl_amt_bits: got %h want 08000000", res); end
    op32(OP_SLL, 32'h1, 32'd31);
    vectors++; if ({res, co, of} !== {32'h8000_0000, 2'b00}) begin miscompares++; $display("FAIL sll: got %h %b want 80000000 00", res, {co, of}); end
    op32(4'b1111, 32'h1234, 32'h5678);
    vectors++; if ({ov, res, z, co, of} !== {1'b1, 32'h0, 3'b100}) begin miscompares++; $display("FAIL undef_op: got %b %h %b want 1 00000000 100", ov, res, {z, co, of}); end
  endtask

  task automatic test_mul;
    logic early = 1'b0;
    op8(OP_MULU, 8'h0F, 8'h11);
    for (int k = 1; k < 8; k++) begin
      if (m_ir !== 1'b0 || m_ov !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (early !== 1'b0 || m_ir !== 1'b0) begin miscompares++; $display("FAIL mul_busy: got early=%b in_ready=%b want 0 0", early, m_ir); end
    @(posedge clk); #1;
    vectors++; if ({m_ov, m_ir} !== 2'b11) begin miscompares++; $display("FAIL mul_latency out_valid/in_ready: got %b want 11", {m_ov, m_ir}); end
    vectors++; if ({m_res, m_z, m_co, m_of} !== {8'hFF, 3'b000}) begin miscompares++; $display("FAIL mul_0f_11: got %h %b want ff 000", m_res, {m_z, m_co, m_of}); end
    op8(OP_MULU, 8'h10, 8'h10);
    vectors++; if (m_ov !== 1'b0) begin miscompares++; $display("FAIL mul_drain out_valid: got %b want 0", m_ov); end
    repeat (8) @(posedge clk);
    #1;
    vectors++; if ({m_ov, m_res, m_z, m_co, m_of} !== {1'b1, 8'h00, 3'b110}) begin miscompares++; $display("FAIL mul_10_10: got %b %h %b want 1 00 110", m_ov, m_res, {m_z, m_co, m_of}); end
    op8(OP_MULU, 8'hFF, 8'hFF);
    repeat (8) @(posedge clk);
    #1;
    vectors++; if ({m_ov, m_res, m_co} !== {1'b1, 8'h01, 1'b1}) begin miscompares++; $display("FAIL mul_ff_ff: got %b %h %b want 1 01 1", m_ov, m_res, m_co); end
  endtask

  task automatic test_back_to_back;
    ordy = 1'b0;
    op32(OP_ADD, 32'd1, 32'd2);
    vectors++; if ({ov, res} !== {1'b1, 32'd3}) begin miscompares++; $display("FAIL bp_first: got %b %h want 1 00000003", ov, res); end
    op = OP_OR; s1 = 32'hAAAA_0000; s2 = 32'h5555; iv = 1'b1;
    #1;
    vectors++; if (ir !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", ir); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({ov, res} !== {1'b1, 32'd3}) begin miscompares++; $display("FAIL bp_hold: got %b %h want 1 00000003", ov, res); end
    ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = OP_ADD; s1 = i; s2 = 32'd100; iv = 1'b1;
      @(posedge clk); #1;
      vectors++; if ({ov, res} !== {1'b1, 32'(i + 100)}) begin miscompares++; $display("FAIL stream_%0d: got %b %h want 1 %h", i, ov, res, 32'(i + 100)); end
    end
    iv = 1'b0;
    @(posedge clk); #1;
    vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL stream_end out_valid: got %b want 0", ov); end
  endtask

  task automatic test_reset_mid_mul;
    logic spurious = 1'b0;
    op8(OP_MULU, 8'h0F, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if ({m_ov, m_ir, m_res, m_co, m_of, m_z} !== {2'b00, 8'h00, 3'b001}) begin miscompares++; $display("FAIL mid_mul_rst: got %b%b %h %b want 00 00 001", m_ov, m_ir, m_res, {m_co, m_of, m_z}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (m_ov !== 1'b0) spurious = 1'b1;
    end
    vectors++; if (spurious !== 1'b0) begin miscompares++; $display("FAIL mid_mul_spurious: got %b want 0", spurious); end
    op8(4'b1111, 8'h5A, 8'hA5);
    vectors++; if ({m_ov, m_res, m_co, m_of} !== {1'b1, 8'h00, 2'b00}) begin miscompares++; $display("FAIL undef8: got %b %h %b want 1 00 00", m_ov, m_res, {m_co, m_of}); end
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_logic;
    test_shift;
    test_mul;
    test_back_to_back;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 32-bit registered ALU. It keeps the existing 4-bit operation encoding and flag semantics, and adds shifts, unsigned set-less-than, and an iterative unsigned multiply. It adds valid/ready flow control on both sides, so it can sit between the decode stage and writeback with back-pressure. Single-cycle ops are pipelined back-to-back. Multiply occupies the block for WIDTH cycles.

## Interface
- WIDTH, default 32: operand/result width, ≥ 4, power of two.
- SHW, default $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B; for shifts, src2[SHW-1:0] is the shift amount.
- alu_control  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, derived combinationally from the result register.
- cout  out  1  carry-out / multiply high-half-nonzero.
- overflow  out  1  signed overflow (ADD/SUB only).

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 1100 NOR; 1101 NAND.
  - 0010 ADD; 0110 SUB (A + ~B + 1).
  - 0111 SLT (signed A<B, correct under overflow); 1001 SLTU.
  - 0011 SLL; 0100 SRL; 0101 SRA.
  - 1000 MULU: low WIDTH bits of A*B, unsigned.
- Any other opcode: result 0, cout 0, overflow 0; a response is still produced.
- ADD/SUB flags:
  - cout = carry out of the MSB; for SUB, 1 means no borrow.
  - overflow = 1 when the operands' effective signs match (B inverted for SUB) and the result sign differs.
- SLT/SLTU: result[WIDTH-1:1] = 0; cout = 0; overflow = 0.
- MULU: cout = 1 if product bits [2·WIDTH-1:WIDTH] are nonzero; overflow = 0.
- All other opcodes: cout = 0, overflow = 0.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - result/flags are held stable while out_valid && !out_ready.
- FSM states:
  - IDLE: accepting. A non-MULU request loads the output registers and sets out_valid. A MULU request latches operands, clears the 2·WIDTH accumulator, sets count = WIDTH, and goes to MUL.
  - MUL: one shift-add step per cycle; count decrements. On the step where count reaches 0, load the output registers, set out_valid, and go to IDLE.
- out_valid clears on an output transfer unless a new request is accepted in the same cycle.
- Request inputs are ignored while in_ready = 0.

## Timing
- Reset (async, immediate): state = IDLE; result = 0; cout = 0; overflow = 0; out_valid = 0; zero therefore = 1.
- in_ready = 0 during reset; it is 1 on the first cycle after release.
- Reset mid-multiply aborts the operation with no output.
- Single-cycle op accepted at edge N: out_valid = 1 and result valid after edge N (latency 1).
- With out_ready held at 1, throughput is one op per cycle.
- MULU accepted at edge N: in_ready = 0 for cycles N+1 … N+WIDTH; result and out_valid appear after edge N+WIDTH.
- MULU accepted while an older result is being drained: the older result is consumed and the multiply starts; out_valid drops after edge N.
- Shift amount ≥ WIDTH is impossible by construction (SHW bits only).
- Arithmetic is carried out at WIDTH+1 bits for carry. The multiply accumulator is 2·WIDTH bits.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND … OP_MULU);
  - the state typedef (IDLE, MUL);
  - a function that decodes whether an opcode is single-cycle.
- Sub-module alu_mul_iter holds the iterative shift-add multiplier and counter, with start/done and a 2·WIDTH product.
- The top level holds the combinational single-cycle datapath, the FSM, and the output registers.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0, out_valid one cycle after accept.
- SUB 5 − 5 → result 0, zero 1, cout 1. Then SLT 0x80000000 vs 0x7FFFFFFF → result 1, and SLTU on the same operands → result 0.
- SRA 0x80000000 by 4 → 0xF8000000. SRL same → 0x08000000. SLL 1 by 31 → 0x80000000.
- WIDTH=8, MULU 0x0F × 0x11 → result 0xFF, cout 0, out_valid after 8 cycles, in_ready low for cycles 1–8. MULU 0x10 × 0x10 → result 0x00, cout 1, zero 1.
- Back-pressure: hold out_ready = 0 with in_valid = 1 → in_ready = 0 and result stable. Then stream 10 ALU ops with out_ready = 1 → 10 results on 10 consecutive cycles, in order.
- Assert rst_n low for one cycle at MUL cycle 3 → all outputs 0, no spurious out_valid. Then opcode 1111 → result 0, flags 0, out_valid 1.
